compare_block_mlog: RTL and testbench

//  Parametrised read-data checker for the memory tester. Compares Avalon-MM readdata

---
 rtl/compare_block_mlog_if.sv | 48 ++++
 rtl/compare_block_mlog.sv | 262 ++++++++++++++++++++++++++
 tb/tb_compare_block_mlog.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/compare_block_mlog_if.sv
// Bundle of command, read-data, status and error-log signals of the memory-tester read checker.
interface compare_block_mlog_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              test_start_i;
    logic              stop_on_err_i;
    logic              readdatavalid_i;
    logic [DATA_W-1:0] readdata_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [LEN_W-1:0]  cmd_words_i;
    logic [7:0]        cmd_ptrn_i;
    logic              cmd_rnd_i;
    logic [OFF_W-1:0]  cmd_start_off_i;
    logic [OFF_W-1:0]  cmd_end_off_i;
    logic              busy_o;
    logic              err_o;
    logic [31:0]       err_cnt_o;
    logic              data_ovf_o;
    logic              log_rd_i;
    logic              log_valid_o;
    logic [ADDR_W-1:0] log_addr_o;
    logic [OFF_W-1:0]  log_byte_o;
    logic [7:0]        log_exp_o;
    logic [7:0]        log_act_o;
    logic              log_ovf_o;

    modport slave (
        input  test_start_i, stop_on_err_i, readdatavalid_i, readdata_i,
               cmd_valid_i, cmd_addr_i, cmd_words_i, cmd_ptrn_i, cmd_rnd_i,
               cmd_start_off_i, cmd_end_off_i, log_rd_i,
        output cmd_ready_o, busy_o, err_o, err_cnt_o, data_ovf_o,
               log_valid_o, log_addr_o, log_byte_o, log_exp_o, log_act_o, log_ovf_o
    );

    modport master (
        output test_start_i, stop_on_err_i, readdatavalid_i, readdata_i,
               cmd_valid_i, cmd_addr_i, cmd_words_i, cmd_ptrn_i, cmd_rnd_i,
               cmd_start_off_i, cmd_end_off_i, log_rd_i,
        input  cmd_ready_o, busy_o, err_o, err_cnt_o, data_ovf_o,
               log_valid_o, log_addr_o, log_byte_o, log_exp_o, log_act_o, log_ovf_o
    );
endinterface

// File: rtl/compare_block_mlog.sv
// Read-data checker: compares queued read words against a fixed or LFSR byte pattern,
// counts failing words and keeps a small FWFT log of the first failing byte of each.
module compare_block_mlog #(
    parameter int DATA_W        = 128,
    parameter int ADDR_W        = 32,
    parameter int LEN_W         = 8,
    parameter int CMD_FIFO_AW   = 2,
    parameter int DATA_FIFO_AW  = 6,
    parameter int ERR_LOG_DEPTH = 4
) (
    input logic clk_i,
    input logic rst_ni,
    compare_block_mlog_if.slave bus
);
    localparam int DATA_B = DATA_W / 8;
    localparam int OFF_W  = $clog2(DATA_B);
    localparam int CMD_D  = 1 << CMD_FIFO_AW;
    localparam int DAT_D  = 1 << DATA_FIFO_AW;
    localparam int LOG_AW = $clog2(ERR_LOG_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, HALT} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  words;
        logic [7:0]        ptrn;
        logic              rnd;
        logic [OFF_W-1:0]  soff;
        logic [OFF_W-1:0]  eoff;
    } cmd_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OFF_W-1:0]  idx;
        logic [7:0]        exp;
        logic [7:0]        act;
    } log_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] p);
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    state_t state, state_nxt;

    cmd_t                  cmd_mem [CMD_D];
    logic [CMD_FIFO_AW:0]  cmd_wp, cmd_rp;
    logic                  cmd_empty, cmd_full, cmd_push, cmd_pop;
    cmd_t                  cmd_head;

    logic [DATA_W-1:0]     dat_mem [DAT_D];
    logic [DATA_FIFO_AW:0] dat_wp, dat_rp;
    logic                  dat_empty, dat_full, dat_push, dat_pop;

    log_t                  log_mem [ERR_LOG_DEPTH];
    logic [LOG_AW:0]       log_wp, log_rp;
    logic                  log_empty, log_full, log_push, log_pop;
    log_t                  log_head;

    logic [LEN_W-1:0]      cur_words, word_idx;
    logic                  cur_rnd;
    logic [OFF_W-1:0]      cur_soff, cur_eoff;
    logic [7:0]            pat;
    logic [ADDR_W-1:0]     waddr;
    logic [DATA_B-1:0]     mask_c;
    logic                  first_word, last_word;

    logic                  vld_p0;
    logic [DATA_W-1:0]     word_p0;
    logic [7:0]            exp_p0;
    logic [ADDR_W-1:0]     addr_p0;
    logic [DATA_B-1:0]     mask_p0;
    logic [DATA_B-1:0]     miss_p0;
    logic [OFF_W-1:0]      miss_idx;
    logic [7:0]            miss_act;
    logic                  halt_req;

    logic                  vld_p1;
    logic [ADDR_W-1:0]     addr_p1;
    logic [OFF_W-1:0]      idx_p1;
    logic [7:0]            exp_p1;
    logic [7:0]            act_p1;

    logic                  err_q, dat_ovf_q, log_ovf_q;
    logic [31:0]           err_cnt_q;

    assign cmd_empty = (cmd_wp == cmd_rp);
    assign cmd_full  = (cmd_wp[CMD_FIFO_AW] != cmd_rp[CMD_FIFO_AW]) &&
                       (cmd_wp[CMD_FIFO_AW-1:0] == cmd_rp[CMD_FIFO_AW-1:0]);
    assign cmd_push  = bus.cmd_valid_i && !cmd_full;
    assign cmd_head  = cmd_mem[cmd_rp[CMD_FIFO_AW-1:0]];

    assign dat_empty = (dat_wp == dat_rp);
    assign dat_full  = (dat_wp[DATA_FIFO_AW] != dat_rp[DATA_FIFO_AW]) &&
                       (dat_wp[DATA_FIFO_AW-1:0] == dat_rp[DATA_FIFO_AW-1:0]);
    assign dat_push  = bus.readdatavalid_i && !dat_full;

    assign log_empty = (log_wp == log_rp);
    assign log_full  = (log_wp[LOG_AW] != log_rp[LOG_AW]) &&
                       (log_wp[LOG_AW-1:0] == log_rp[LOG_AW-1:0]);
    assign log_pop   = bus.log_rd_i && !log_empty;
    // A full log still accepts a new entry when the head is popped in the same cycle.
    assign log_push  = vld_p1 && (!log_full || log_pop);
    assign log_head  = log_mem[log_rp[LOG_AW-1:0]];

    // Word-position mask for the word about to be popped.
    always_comb begin
        first_word = (word_idx == '0);
        last_word  = (word_idx == cur_words);
        mask_c     = '0;
        for (int b = 0; b < DATA_B; b++) begin
            mask_c[b] = (!first_word || (OFF_W'(b) >= cur_soff)) &&
                        (!last_word  || (OFF_W'(b) <= cur_eoff));
        end
    end

    // Stage p0 -> p1: byte compare; lowest failing byte wins.
    always_comb begin
        miss_p0  = '0;
        miss_idx = '0;
        miss_act = '0;
        for (int b = 0; b < DATA_B; b++) begin
            miss_p0[b] = mask_p0[b] && (word_p0[8*b +: 8] != exp_p0);
        end
        for (int b = DATA_B - 1; b >= 0; b--) begin
            if (miss_p0[b]) begin
                miss_idx = OFF_W'(b);
                miss_act = word_p0[8*b +: 8];
            end
        end
    end

    // Halting is decided while the failing word is compared, so no later word is popped.
    assign halt_req = bus.stop_on_err_i && vld_p0 && (|miss_p0);

    always_comb begin
        state_nxt = state;
        cmd_pop   = 1'b0;
        dat_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (halt_req) begin
                    state_nxt = HALT;
                end else if (!cmd_empty) begin
                    cmd_pop   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: state_nxt = halt_req ? HALT : CHECK;
            CHECK: begin
                if (halt_req) begin
                    state_nxt = HALT;
                end else if (!dat_empty) begin
                    dat_pop = 1'b1;
                    if (last_word) state_nxt = IDLE;
                end
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cmd_wp    <= '0;
            cmd_rp    <= '0;
            dat_wp    <= '0;
            dat_rp    <= '0;
            log_wp    <= '0;
            log_rp    <= '0;
            word_idx  <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            dat_ovf_q <= 1'b0;
            log_ovf_q <= 1'b0;
        end else if (bus.test_start_i) begin
            state     <= IDLE;
            cmd_wp    <= '0;
            cmd_rp    <= '0;
            dat_wp    <= '0;
            dat_rp    <= '0;
            log_wp    <= '0;
            log_rp    <= '0;
            word_idx  <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            dat_ovf_q <= 1'b0;
            log_ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_push) cmd_wp <= cmd_wp + 1'b1;
            if (cmd_pop)  cmd_rp <= cmd_rp + 1'b1;
            if (dat_push) dat_wp <= dat_wp + 1'b1;
            if (dat_pop)  dat_rp <= dat_rp + 1'b1;
            if (bus.readdatavalid_i && dat_full) dat_ovf_q <= 1'b1;
            if (state == LOAD)  word_idx <= '0;
            else if (dat_pop)   word_idx <= word_idx + 1'b1;
            vld_p0 <= dat_pop;
            vld_p1 <= vld_p0 && (|miss_p0);
            // Stage p1 -> status: count, flag and log the failing word.
            if (vld_p1) begin
                err_cnt_q <= sat_inc(err_cnt_q);
                err_q     <= 1'b1;
                if (!log_push) log_ovf_q <= 1'b1;
            end
            if (log_push) log_wp <= log_wp + 1'b1;
            if (log_pop)  log_rp <= log_rp + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmd_push) begin
            cmd_mem[cmd_wp[CMD_FIFO_AW-1:0]] <= '{bus.cmd_addr_i, bus.cmd_words_i, bus.cmd_ptrn_i,
                                                 bus.cmd_rnd_i, bus.cmd_start_off_i, bus.cmd_end_off_i};
        end
        if (dat_push) dat_mem[dat_wp[DATA_FIFO_AW-1:0]] <= bus.readdata_i;
        if (log_push) log_mem[log_wp[LOG_AW-1:0]] <= '{addr_p1, idx_p1, exp_p1, act_p1};
        if (cmd_pop) begin
            cur_words <= cmd_head.words;
            cur_rnd   <= cmd_head.rnd;
            cur_soff  <= cmd_head.soff;
            cur_eoff  <= cmd_head.eoff;
            pat       <= cmd_head.ptrn;
            waddr     <= cmd_head.addr;
        end else if (dat_pop) begin
            pat   <= cur_rnd ? lfsr_next(pat) : pat;
            waddr <= waddr + 1'b1;
        end
        // Pop -> stage p0.
        if (dat_pop) begin
            word_p0 <= dat_mem[dat_rp[DATA_FIFO_AW-1:0]];
            exp_p0  <= pat;
            addr_p0 <= waddr;
            mask_p0 <= mask_c;
        end
        // Stage p0 -> p1.
        addr_p1 <= addr_p0;
        idx_p1  <= miss_idx;
        exp_p1  <= exp_p0;
        act_p1  <= miss_act;
    end

    assign bus.cmd_ready_o = !cmd_full;
    assign bus.busy_o      = (state == LOAD) || (state == CHECK) ||
                             ((state != HALT) && (!cmd_empty || vld_p0 || vld_p1));
    assign bus.err_o       = err_q;
    assign bus.err_cnt_o   = err_cnt_q;
    assign bus.data_ovf_o  = dat_ovf_q;
    assign bus.log_ovf_o   = log_ovf_q;
    assign bus.log_valid_o = !log_empty;
    assign bus.log_addr_o  = log_empty ? '0 : log_head.addr;
    assign bus.log_byte_o  = log_empty ? '0 : log_head.idx;
    assign bus.log_exp_o   = log_empty ? '0 : log_head.exp;
    assign bus.log_act_o   = log_empty ? '0 : log_head.act;
endmodule

// File: tb/tb_compare_block_mlog.sv
// Directed bench for compare_block_mlog; a monitor drains the error log against a queue
// of expected entries filled by the stimulus thread.
module tb_compare_block_mlog;
    localparam int DATA_W = 128;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 8;
    localparam int DATA_B = DATA_W / 8;
    localparam int OFF_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    compare_block_mlog_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    compare_block_mlog #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
        .CMD_FIFO_AW(2), .DATA_FIFO_AW(6), .ERR_LOG_DEPTH(4)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [OFF_W-1:0]  idx;
        logic [7:0]        exp;
        logic [7:0]        act;
    } ent_t;

    ent_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] fill(input logic [7:0] b);
        return {DATA_B{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] words,
                            input logic [7:0] ptrn, input logic rnd,
                            input logic [OFF_W-1:0] soff, input logic [OFF_W-1:0] eoff);
        int n;
        for (n = 0; n < 50 && !bus.cmd_ready_o; n++) tick();
        if (n == 50) begin
            total++;
            bad++;
            $display("FAIL cmd_ready timeout: got 0 want 1");
        end
        bus.cmd_addr_i      = addr;
        bus.cmd_words_i     = words;
        bus.cmd_ptrn_i      = ptrn;
        bus.cmd_rnd_i       = rnd;
        bus.cmd_start_off_i = soff;
        bus.cmd_end_off_i   = eoff;
        bus.cmd_valid_i     = 1'b1;
        tick();
        bus.cmd_valid_i     = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d);
        bus.readdata_i      = d;
        bus.readdatavalid_i = 1'b1;
        tick();
        bus.readdatavalid_i = 1'b0;
    endtask

    task automatic start_pulse();
        bus.test_start_i = 1'b1;
        tick();
        bus.test_start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!bus.busy_o) break;
        end
        if (n == 200) begin
            total++;
            bad++;
            $display("FAIL %s idle timeout: busy_o got 1 want 0", name);
        end
        tick();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Log monitor: compares and pops every presented entry while enabled.
    initial begin
        ent_t e;
        bus.log_rd_i = 1'b0;
        forever begin
            @(negedge clk);
            bus.log_rd_i = 1'b0;
            if (mon_en && bus.log_valid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL log unexpected: got addr 0x%0h byte %0d want no entry",
                             bus.log_addr_o, bus.log_byte_o);
                end else begin
                    e = exp_q.pop_front();
                    check("log_addr", 64'(bus.log_addr_o), 64'(e.addr));
                    check("log_byte", 64'(bus.log_byte_o), 64'(e.idx));
                    check("log_exp",  64'(bus.log_exp_o),  64'(e.exp));
                    check("log_act",  64'(bus.log_act_o),  64'(e.act));
                end
                bus.log_rd_i = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] w;

        bus.test_start_i    = 1'b0;
        bus.stop_on_err_i   = 1'b0;
        bus.readdatavalid_i = 1'b0;
        bus.readdata_i      = '0;
        bus.cmd_valid_i     = 1'b0;
        bus.cmd_addr_i      = '0;
        bus.cmd_words_i     = '0;
        bus.cmd_ptrn_i      = '0;
        bus.cmd_rnd_i       = 1'b0;
        bus.cmd_start_off_i = '0;
        bus.cmd_end_off_i   = '0;

        // Reset state
        #12;
        check("rst cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
        check("rst busy",      64'(bus.busy_o),      64'd0);
        check("rst err",       64'(bus.err_o),       64'd0);
        check("rst err_cnt",   64'(bus.err_cnt_o),   64'd0);
        check("rst log_valid", 64'(bus.log_valid_o), 64'd0);
        check("rst data_ovf",  64'(bus.data_ovf_o),  64'd0);
        check("rst log_ovf",   64'(bus.log_ovf_o),   64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: four matching fixed-pattern words
        mon_en = 1'b1;
        push_cmd(32'h10, 8'd3, 8'hA5, 1'b0, 4'd0, 4'd15);
        for (int i = 0; i < 4; i++) send_word(fill(8'hA5));
        wait_idle("t1");
        check("t1 err_cnt",   64'(bus.err_cnt_o),   64'd0);
        check("t1 err",       64'(bus.err_o),       64'd0);
        check("t1 busy",      64'(bus.busy_o),      64'd0);
        check("t1 log_valid", 64'(bus.log_valid_o), 64'd0);

        // 2: word 2 byte 5 corrupted, continue on error
        start_pulse();
        exp_q.push_back('{32'h12, 4'd5, 8'hA5, 8'h00});
        push_cmd(32'h10, 8'd3, 8'hA5, 1'b0, 4'd0, 4'd15);
        for (int i = 0; i < 4; i++) begin
            w = fill(8'hA5);
            if (i == 2) w[8*5 +: 8] = 8'h00;
            send_word(w);
        end
        wait_idle("t2");
        idle_cycles(5);
        check("t2 err_cnt", 64'(bus.err_cnt_o), 64'd1);
        check("t2 err",     64'(bus.err_o),     64'd1);
        check("t2 log drained", 64'(exp_q.size()), 64'd0);
        check("t2 log_valid",   64'(bus.log_valid_o), 64'd0);

        // 3: LFSR seed 0x01 (words 0x01,0x02,0x04), halt on word 1
        start_pulse();
        bus.stop_on_err_i = 1'b1;
        exp_q.push_back('{32'h101, 4'd0, 8'h02, 8'hFF});
        push_cmd(32'h100, 8'd2, 8'h01, 1'b1, 4'd0, 4'd15);
        send_word(fill(8'h01));
        w = fill(8'h02); w[7:0] = 8'hFF; send_word(w);
        w = fill(8'h04); w[7:0] = 8'hFF; send_word(w);
        idle_cycles(20);
        check("t3 err_cnt halted", 64'(bus.err_cnt_o), 64'd1);
        check("t3 busy halted",    64'(bus.busy_o),    64'd0);
        check("t3 err",            64'(bus.err_o),     64'd1);
        check("t3 log drained",    64'(exp_q.size()),  64'd0);
        bus.stop_on_err_i = 1'b0;
        start_pulse();
        check("t3 clr err_cnt",   64'(bus.err_cnt_o),   64'd0);
        check("t3 clr err",       64'(bus.err_o),       64'd0);
        check("t3 clr log_valid", 64'(bus.log_valid_o), 64'd0);
        push_cmd(32'h600, 8'd0, 8'h5A, 1'b0, 4'd0, 4'd15);
        send_word(fill(8'h5A));
        wait_idle("t3b");
        check("t3 data fifo cleared", 64'(bus.err_cnt_o), 64'd0);

        // 4: single-word byte masking
        start_pulse();
        push_cmd(32'h200, 8'd0, 8'h3C, 1'b0, 4'd2, 4'd5);
        w = fill(8'h3C); w[7:0] = 8'h00; w[15:8] = 8'h00; w[55:48] = 8'h00;
        send_word(w);
        wait_idle("t4a");
        check("t4 masked err_cnt", 64'(bus.err_cnt_o), 64'd0);
        exp_q.push_back('{32'h300, 4'd3, 8'h3C, 8'h99});
        push_cmd(32'h300, 8'd0, 8'h3C, 1'b0, 4'd2, 4'd5);
        w = fill(8'h3C); w[15:8] = 8'h00; w[31:24] = 8'h99;
        send_word(w);
        wait_idle("t4b");
        check("t4 byte3 err_cnt", 64'(bus.err_cnt_o), 64'd1);
        push_cmd(32'h500, 8'd0, 8'h3C, 1'b0, 4'd6, 4'd2);
        send_word(fill(8'h00));
        wait_idle("t4c");
        idle_cycles(5);
        check("t4 empty mask err_cnt", 64'(bus.err_cnt_o), 64'd1);
        check("t4 log drained",        64'(exp_q.size()),  64'd0);

        // 5: six bad words with no log reads
        start_pulse();
        mon_en = 1'b0;
        push_cmd(32'h400, 8'd5, 8'h11, 1'b0, 4'd0, 4'd15);
        for (int i = 0; i < 6; i++) begin
            w = fill(8'h11);
            w[8*i +: 8] = 8'hEE;
            send_word(w);
        end
        wait_idle("t5");
        check("t5 err_cnt",   64'(bus.err_cnt_o),   64'd6);
        check("t5 log_ovf",   64'(bus.log_ovf_o),   64'd1);
        check("t5 log_valid", 64'(bus.log_valid_o), 64'd1);
        exp_q.push_back('{32'h400, 4'd0, 8'h11, 8'hEE});
        exp_q.push_back('{32'h401, 4'd1, 8'h11, 8'hEE});
        exp_q.push_back('{32'h402, 4'd2, 8'h11, 8'hEE});
        exp_q.push_back('{32'h403, 4'd3, 8'h11, 8'hEE});
        mon_en = 1'b1;
        idle_cycles(10);
        check("t5 log drained",   64'(exp_q.size()),    64'd0);
        check("t5 log empty",     64'(bus.log_valid_o), 64'd0);

        // Data FIFO overflow
        start_pulse();
        for (int i = 0; i < 64; i++) send_word(fill(8'h00));
        check("ovf at full", 64'(bus.data_ovf_o), 64'd0);
        send_word(fill(8'h00));
        check("ovf dropped", 64'(bus.data_ovf_o), 64'd1);
        start_pulse();
        check("ovf cleared", 64'(bus.data_ovf_o), 64'd0);

        // 6: asynchronous reset in the middle of a command
        mon_en = 1'b0;
        push_cmd(32'h700, 8'd3, 8'h77, 1'b0, 4'd0, 4'd15);
        send_word(fill(8'h00));
        send_word(fill(8'h77));
        idle_cycles(6);
        check("t6 err_cnt before", 64'(bus.err_cnt_o), 64'd1);
        check("t6 busy before",    64'(bus.busy_o),    64'd1);
        #3 rst_n = 1'b0;
        #1;
        check("t6 async err_cnt",   64'(bus.err_cnt_o),   64'd0);
        check("t6 async err",       64'(bus.err_o),       64'd0);
        check("t6 async busy",      64'(bus.busy_o),      64'd0);
        check("t6 async cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
        check("t6 async log_valid", 64'(bus.log_valid_o), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        push_cmd(32'h800, 8'd0, 8'h42, 1'b0, 4'd0, 4'd15);
        send_word(fill(8'h42));
        wait_idle("t6");
        check("t6 fresh err_cnt", 64'(bus.err_cnt_o), 64'd0);
        check("t6 fresh err",     64'(bus.err_o),     64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
